// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, fixed encodings and
// address/field widths used by the fetch stage and its next-PC selector.
package mips_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;
  localparam int JIDX_W     = 26;

  localparam logic [XLEN-1:0] NOP     = 32'h0000_0000;
  localparam logic [XLEN-1:0] SYSCALL = 32'h0000_000C;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: jr > jump > taken branch > sequential, with the
// branch/jump target adders. Redirects only count for a live IR word.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   id_pc_plus4,
  input  logic              qualify,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              jr,
  input  logic [XLEN-1:0]   jr_target,
  output logic [XLEN-1:0]   next_pc,
  output logic              redirect
);

  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;

  assign seq_target = pc + XLEN'(WORD_BYTES);
  assign br_target  = id_pc_plus4 + (br_offset << 2);
  assign j_target   = {id_pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc  = seq_target;
    redirect = 1'b0;
    if (qualify) begin
      if (jr) begin
        next_pc  = jr_target;
        redirect = 1'b1;
      end else if (jump) begin
        next_pc  = j_target;
        redirect = 1'b1;
      end else if (br_taken) begin
        next_pc  = br_target;
        redirect = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC, instruction register and BOOT/RUN/HALT control.
// Define PC_FETCH_DELAY_SLOT_EN to keep the fall-through word after a redirect.
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] HALT_WORD  = SYSCALL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              jr,
  input  logic [XLEN-1:0]   jr_target,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_data,
  output logic [XLEN-1:0]   instr,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   id_pc_plus4,
  output logic              instr_valid,
  output logic              halted,
  output logic              fetch_fault
);

  // 33-bit limit so a depth covering the whole 4 GiB space never faults.
  localparam logic [XLEN:0] PC_LIMIT = {1'b0, IMEM_DEPTH} << 2;

`ifdef PC_FETCH_DELAY_SLOT_EN
  localparam bit SQUASH_SLOT = 1'b0;
`else
  localparam bit SQUASH_SLOT = 1'b1;
`endif

  fetch_state_t    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] ir_reg;
  logic [XLEN-1:0] id_pc_reg;
  logic            valid_reg;
  logic            halted_reg;
  logic            fault_reg;

  logic [XLEN-1:0] pc_next;
  logic            redirect;
  logic            squash;
  logic            out_of_range;
  logic            halt_hit;

  assign id_pc_plus4  = id_pc_reg + XLEN'(WORD_BYTES);
  assign out_of_range = ({1'b0, pc_reg} >= PC_LIMIT);
  assign halt_hit     = (imem_data == HALT_WORD);
  assign squash       = SQUASH_SLOT & redirect;

  next_pc_sel u_next_pc_sel (
    .pc          (pc_reg),
    .id_pc_plus4 (id_pc_plus4),
    .qualify     (valid_reg),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .jump        (jump),
    .jump_index  (jump_index),
    .jr          (jr),
    .jr_target   (jr_target),
    .next_pc     (pc_next),
    .redirect    (redirect)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= BOOT;
      pc_reg     <= RESET_PC;
      ir_reg     <= NOP;
      id_pc_reg  <= RESET_PC;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: state_reg <= RUN;
        RUN: begin
          if (!stall) begin
            if (out_of_range) begin
              ir_reg     <= NOP;
              valid_reg  <= 1'b0;
              fault_reg  <= 1'b1;
              halted_reg <= 1'b1;
              state_reg  <= HALT;
            end else begin
              id_pc_reg <= pc_reg;
              if (squash) begin
                ir_reg    <= NOP;
                valid_reg <= 1'b0;
                pc_reg    <= pc_next;
              end else begin
                ir_reg    <= imem_data;
                valid_reg <= 1'b1;
                // A captured syscall freezes the PC on its own address.
                if (halt_hit) begin
                  halted_reg <= 1'b1;
                  state_reg  <= HALT;
                end else begin
                  pc_reg <= pc_next;
                end
              end
            end
          end
        end
        HALT: begin
          ir_reg    <= NOP;
          valid_reg <= 1'b0;
        end
        default: state_reg <= HALT;
      endcase
    end
  end

  assign imem_addr   = pc_reg;
  assign instr       = ir_reg;
  assign id_pc       = id_pc_reg;
  assign instr_valid = valid_reg;
  assign halted      = halted_reg;
  assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: one 256-word instance and one full-space
// instance (for high-address jump/priority cases) share the same stimulus.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, jump, jr;
  logic [31:0] br_offset, jr_target;
  logic [25:0] jump_index;

  logic [31:0] s_addr, s_data, s_instr, s_id_pc, s_pc4;
  logic        s_valid, s_halted, s_fault;
  logic [31:0] b_addr, b_data, b_instr, b_id_pc, b_pc4;
  logic        b_valid, b_halted, b_fault;

  logic [31:0]  rom [0:255];
  logic [127:0] got, exp;
  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] WA = 32'h2408_0001;
  localparam logic [31:0] WB = 32'h2409_0002;
  localparam logic [31:0] WC = 32'h012A_5020;
  localparam logic [31:0] WD = 32'h1000_FFFE;

  always #5 clk = ~clk;

  always_comb begin
    s_data = (s_addr < 32'h400) ? rom[s_addr[9:2]] : 32'hDEAD_BEEF;
    b_data = (b_addr < 32'h400) ? rom[b_addr[9:2]] : {16'h5A5A, b_addr[15:0]};
  end

  pc_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(256), .HALT_WORD(32'h0000_000C)) u_small (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .imem_addr(s_addr), .imem_data(s_data), .instr(s_instr), .id_pc(s_id_pc),
    .id_pc_plus4(s_pc4), .instr_valid(s_valid), .halted(s_halted), .fetch_fault(s_fault)
  );

  pc_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(32'h4000_0000), .HALT_WORD(32'h0000_000C)) u_big (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .imem_addr(b_addr), .imem_data(b_data), .instr(b_instr), .id_pc(b_id_pc),
    .id_pc_plus4(b_pc4), .instr_valid(b_valid), .halted(b_halted), .fetch_fault(b_fault)
  );

  task automatic clear_inputs();
    stall = 0; br_taken = 0; jump = 0; jr = 0;
    br_offset = 0; jr_target = 0; jump_index = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    #2;
    rst_n = 1;
  endtask

  task automatic test_reset();
    #1;
    got = {s_addr, s_instr, s_id_pc, s_valid, s_halted, s_fault};
    exp = {32'h0, 32'h0, 32'h0, 3'b000};
    if (got !== exp) begin $display("FAIL reset_values: got %h required %h", got, exp); fails++; end
    else $display("ok reset_values");
    checks++;
    @(negedge clk);
    rst_n = 1;
    step(1);
    got = {s_addr, s_instr, s_valid};
    exp = {32'h0, 32'h0, 1'b0};
    if (got !== exp) begin $display("FAIL boot_edge1: got %h required %h", got, exp); fails++; end
    else $display("ok boot_edge1");
    checks++;
    step(1);
    got = {s_instr, s_id_pc, s_pc4, s_valid, s_addr};
    exp = {WA, 32'h0, 32'h4, 1'b1, 32'h4};
    if (got !== exp) begin $display("FAIL boot_edge2: got %h required %h", got, exp); fails++; end
    else $display("ok boot_edge2");
    checks++;
    step(1);
    got = {s_instr, s_id_pc, s_valid, s_addr};
    exp = {WB, 32'h4, 1'b1, 32'h8};
    if (got !== exp) begin $display("FAIL boot_edge3: got %h required %h", got, exp); fails++; end
    else $display("ok boot_edge3");
    checks++;
  endtask

  task automatic test_branch();
    do_reset();
    step(6);
    br_taken = 1; br_offset = 32'hFFFF_FFFE;
    step(1);
    got = {s_addr, s_id_pc, s_valid, s_instr};
`ifdef PC_FETCH_DELAY_SLOT_EN
    exp = {32'h0C, 32'h14, 1'b1, rom[5]};
    br_taken = 0;
`else
    exp = {32'h0C, 32'h14, 1'b0, 32'h0};
`endif
    if (got !== exp) begin $display("FAIL branch_slot: got %h required %h", got, exp); fails++; end
    else $display("ok branch_slot");
    checks++;
    step(1);
    got = {s_addr, s_id_pc, s_valid, s_instr};
    exp = {32'h10, 32'h0C, 1'b1, WD};
    if (got !== exp) begin $display("FAIL branch_target: got %h required %h", got, exp); fails++; end
    else $display("ok branch_target");
    checks++;
    clear_inputs();
  endtask

  task automatic test_priority();
    logic [31:0] want;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      step(2);
      jr = 1; jr_target = 32'h3000_0008;
      step(1);
      jr = 0;
      step(1);
      got = {b_id_pc, b_valid, b_addr};
      exp = {32'h3000_0008, 1'b1, 32'h3000_000C};
      if (got !== exp) begin $display("FAIL prio_setup%0d: got %h required %h", k, got, exp); fails++; end
      else $display("ok prio_setup%0d", k);
      checks++;
      jr = (k == 0); jump = (k < 2); br_taken = 1;
      jr_target = 32'h40; jump_index = 26'h10; br_offset = 32'd5;
      want = (k == 0) ? 32'h40 : (k == 1) ? 32'h3000_0040 : 32'h3000_0020;
      step(1);
      if (b_addr !== want) begin $display("FAIL prio_pc%0d: got %h required %h", k, b_addr, want); fails++; end
      else $display("ok prio_pc%0d", k);
      checks++;
      clear_inputs();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(2);
    jr = 1; jr_target = 32'hFFFF_FFFC;
    step(1);
    jr = 0;
    step(1);
    got = {b_addr, b_id_pc};
    exp = {32'h0, 32'hFFFF_FFFC};
    if (got !== exp) begin $display("FAIL pc_wrap: got %h required %h", got, exp); fails++; end
    else $display("ok pc_wrap");
    checks++;
    do_reset();
    step(2);
    jr = 1; jr_target = 32'h0000_0103;
    step(1);
    jr = 0;
    if (s_addr !== 32'h103) begin $display("FAIL jr_misaligned: got %h required %h", s_addr, 32'h103); fails++; end
    else $display("ok jr_misaligned");
    checks++;
  endtask

  task automatic test_stall();
    do_reset();
    step(4);
    jump = 1; jump_index = 26'h8; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      got = {s_addr, s_instr, s_id_pc, s_valid};
      exp = {32'h0C, rom[2], 32'h8, 1'b1};
      if (got !== exp) begin $display("FAIL stall_hold%0d: got %h required %h", i, got, exp); fails++; end
      else $display("ok stall_hold%0d", i);
      checks++;
    end
    stall = 0;
    step(1);
    got = {s_addr, s_id_pc, s_valid, s_instr};
`ifdef PC_FETCH_DELAY_SLOT_EN
    exp = {32'h20, 32'h0C, 1'b1, WD};
`else
    exp = {32'h20, 32'h0C, 1'b0, 32'h0};
`endif
    if (got !== exp) begin $display("FAIL stall_release: got %h required %h", got, exp); fails++; end
    else $display("ok stall_release");
    checks++;
    clear_inputs();
  endtask

  task automatic test_halt();
    rom[2] = 32'h0000_000C;
    do_reset();
    step(4);
    got = {s_instr, s_valid, s_halted, s_fault, s_addr, s_id_pc};
    exp = {32'hC, 1'b1, 1'b1, 1'b0, 32'h8, 32'h8};
    if (got !== exp) begin $display("FAIL halt_capture: got %h required %h", got, exp); fails++; end
    else $display("ok halt_capture");
    checks++;
    step(1);
    got = {s_instr, s_valid, s_halted, s_addr};
    exp = {32'h0, 1'b0, 1'b1, 32'h8};
    if (got !== exp) begin $display("FAIL halt_flush: got %h required %h", got, exp); fails++; end
    else $display("ok halt_flush");
    checks++;
    jr = 1; jr_target = 32'h40; br_taken = 1;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      step(1);
      got = {s_addr, s_instr, s_valid, s_halted, s_fault};
      exp = {32'h8, 32'h0, 1'b0, 1'b1, 1'b0};
      if (got !== exp) begin $display("FAIL halt_hold%0d: got %h required %h", i, got, exp); fails++; end
      else $display("ok halt_hold%0d", i);
      checks++;
    end
    #3;
    rst_n = 0;
    #1;
    got = {s_addr, s_instr, s_id_pc, s_valid, s_halted, s_fault};
    exp = {32'h0, 32'h0, 32'h0, 3'b000};
    if (got !== exp) begin $display("FAIL async_reset: got %h required %h", got, exp); fails++; end
    else $display("ok async_reset");
    checks++;
    clear_inputs();
    rom[2] = WC;
    #1;
    rst_n = 1;
    step(1);
    got = {s_addr, s_valid, s_halted};
    exp = {32'h0, 1'b0, 1'b0};
    if (got !== exp) begin $display("FAIL reboot_edge1: got %h required %h", got, exp); fails++; end
    else $display("ok reboot_edge1");
    checks++;
    step(1);
    got = {s_instr, s_valid, s_addr};
    exp = {WA, 1'b1, 32'h4};
    if (got !== exp) begin $display("FAIL reboot_edge2: got %h required %h", got, exp); fails++; end
    else $display("ok reboot_edge2");
    checks++;
  endtask

  task automatic test_fault();
    do_reset();
    step(2);
    jr = 1; jr_target = 32'h3FC;
    step(1);
    jr = 0;
    step(1);
    got = {s_id_pc, s_instr, s_valid, s_fault, s_addr};
    exp = {32'h3FC, rom[255], 1'b1, 1'b0, 32'h400};
    if (got !== exp) begin $display("FAIL last_word: got %h required %h", got, exp); fails++; end
    else $display("ok last_word");
    checks++;
    step(1);
    got = {s_fault, s_halted, s_valid, s_instr, s_addr};
    exp = {1'b1, 1'b1, 1'b0, 32'h0, 32'h400};
    if (got !== exp) begin $display("FAIL fault_seq: got %h required %h", got, exp); fails++; end
    else $display("ok fault_seq");
    checks++;
    do_reset();
    step(2);
    jr = 1; jr_target = 32'h400;
    step(1);
    jr = 0;
    step(1);
    got = {s_fault, s_halted, s_valid, s_instr, s_addr};
    exp = {1'b1, 1'b1, 1'b0, 32'h0, 32'h400};
    if (got !== exp) begin $display("FAIL fault_jr: got %h required %h", got, exp); fails++; end
    else $display("ok fault_jr");
    checks++;
    step(3);
    got = {s_fault, s_halted, s_valid, s_addr};
    exp = {1'b1, 1'b1, 1'b0, 32'h400};
    if (got !== exp) begin $display("FAIL fault_sticky: got %h required %h", got, exp); fails++; end
    else $display("ok fault_sticky");
    checks++;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 + i;
    rom[0] = WA; rom[1] = WB; rom[2] = WC; rom[3] = WD;
    test_reset();
    test_branch();
    test_priority();
    test_wrap();
    test_stall();
    test_halt();
    test_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction ROM.
- Holds the program counter and drives the ROM word address.
- Captures the returned instruction word into an instruction register (IR) with its PC.
- Selects the next PC from sequential, branch, jump and jump-register sources. Supports stall, squash, halt-on-syscall and out-of-range fault.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words; valid byte range is [0, 4*IMEM_DEPTH).
- HALT_WORD, 32'h0000_000C, instruction encoding (syscall) that halts fetch.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freeze PC and IR this cycle.
- br_taken  in  1  conditional branch in IR resolved taken.
- br_offset  in  32  sign-extended branch immediate, in words.
- jump  in  1  J/JAL in IR.
- jump_index  in  26  instr_index field of J/JAL.
- jr  in  1  JR/JALR in IR.
- jr_target  in  32  register-sourced byte target.
- imem_addr  out  32  byte address to ROM; equals pc.
- imem_data  in  32  combinational ROM read data.
- instr  out  32  IR contents.
- id_pc  out  32  byte address of instr.
- id_pc_plus4  out  32  id_pc + 4.
- instr_valid  out  1  instr is live (not squashed or NOP-filled).
- halted  out  1  fetch stopped, sticky until reset.
- fetch_fault  out  1  PC left the IMEM range, sticky until reset.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc = RESET_PC; instr = 32'h0 (NOP); id_pc = RESET_PC; instr_valid = 0; halted = 0; fetch_fault = 0; state = BOOT.
- FSM states BOOT, RUN, HALT. The state is encoded in 2 bits.
- BOOT:
  - Lasts exactly one clock after reset release.
  - PC is not advanced and IR is not loaded.
  - Next state is RUN.
  - The first instruction appears in IR on the second rising edge after release.
- RUN, on each edge with stall = 0:
  - IR <= imem_data; id_pc <= pc; instr_valid <= 1; pc <= next_pc.
- Next-PC priority (exactly one source is used):
  - jr: jr_target.
  - else jump: {id_pc_plus4[31:28], jump_index, 2'b00}.
  - else br_taken: id_pc_plus4 + (br_offset << 2). Arithmetic is 32-bit, wraps modulo 2^32, and carry is discarded.
  - else: pc + 4, wrapping from 32'hFFFF_FFFC to 0.
- Redirect and squash:
  - Redirect inputs qualify only when instr_valid = 1; otherwise they are ignored.
  - On a qualified redirect, the word fetched in the same cycle is the fall-through slot.
  - Without the optional feature, that slot is squashed: IR <= 32'h0 and instr_valid <= 0.
- Stall:
  - stall = 1 has priority over everything. pc, IR, id_pc, instr_valid and state all hold.
  - Redirect inputs are not sampled during stall; upstream holds them stable because they derive from the frozen IR.
- Halt:
  - In RUN, if imem_data == HALT_WORD and the word is not squashed, it is captured with instr_valid = 1.
  - State moves to HALT and halted <= 1 on that edge. pc holds.
  - In HALT, the next edge loads IR <= 0 and instr_valid <= 0; thereafter everything holds.
  - stall, redirects and imem_data are ignored. Only reset leaves HALT.
- Fault:
  - In RUN with stall = 0 and pc >= 4*IMEM_DEPTH (unsigned), there is no capture.
  - IR <= 0, instr_valid <= 0, fetch_fault <= 1, halted <= 1, state moves to HALT.
  - The fault check takes priority over the HALT_WORD check.
- Reset asserted mid-operation (any state, any stall) immediately forces all reset values.
- imem_addr is pc, combinationally; pc is always word-aligned except when loaded from jr_target. A misaligned jr_target is passed through unmodified.

Optional Feature:
- Macro PC_FETCH_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot. On a qualified redirect, the fall-through word is captured with instr_valid = 1 and not squashed; HALT_WORD in the slot still halts.
- Undefined: the slot is squashed as described under Behaviour.

Decomposition:
- Shared package mips_pkg:
  - FSM state typedef (BOOT/RUN/HALT).
  - NOP constant 32'h0.
  - SYSCALL constant 32'h0000_000C.
  - Word/byte-address width constants.
- One natural sub-module, next_pc_sel: combinational priority mux plus target adders, instantiated once.
- PC, IR and FSM stay in pc_fetch.

Test Plan:
- Reset release with RESET_PC = 0 and ROM words 0..3 = A,B,C,D: IR holds A at edge 2, B at edge 3; imem_addr goes 0, 0, 4, 8; instr_valid goes 0, 1, 1.
- Branch: IR is a branch at id_pc = 0x10, br_offset = -2, br_taken = 1:
  - Next pc = 0x0C.
  - The slot word at 0x14 is loaded with instr_valid = 0, or with instr_valid = 1 under PC_FETCH_DELAY_SLOT_EN.
- Priority: jr = jump = br_taken = 1, jr_target = 0x40, id_pc = 0x3000_0008, jump_index = 0x10 → pc = 0x40. With jr deasserted → pc = 0x3000_0040.
- Stall of 3 cycles mid-stream with redirect asserted: pc, IR and instr_valid stay unchanged for 3 edges; the redirect takes effect on the first unstalled edge.
- Halt/fault:
  - SYSCALL at 0x8: captured with valid = 1, then halted = 1 and valid = 0 on the next edge; pc stays 0x8 for 10 cycles.
  - Separately, jr_target = 0x400 with IMEM_DEPTH = 256 → fetch_fault = 1 and halted = 1.
- Asynchronous reset pulse asserted between edges while in HALT: all outputs return to reset values immediately; the BOOT sequence repeats.
